// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit with HI/LO registers for the EX stage.
// Optional accumulate ops (maddu/madd/msubu/msub) enabled by MD_UNIT_MADD_EN.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    localparam int CMAX = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE_DIV} mdState_t;

    mdState_t         state;
    logic [CW-1:0]    count;
    logic [3:0]       opReg;
    logic [WIDTH-1:0] aReg, bReg;
    logic [WIDTH-1:0] divisor, quo, rem;
    logic             negQ, negR, divZero;

    logic               isMulOp, isDivOp, startSigned;
    logic [WIDTH-1:0]   aMag, bMag;
    logic               mulSigned;
    logic [2*WIDTH-1:0] aExt, bExt, product, mulResult;
    logic [WIDTH:0]     shifted;
    logic               stepGeq;
    logic [WIDTH-1:0]   stepDiff, quoFinal, remFinal;

    always_comb begin
        isMulOp = (op == 4'd1) || (op == 4'd2);
`ifdef MD_UNIT_MADD_EN
        isMulOp = isMulOp || ((op >= 4'd7) && (op <= 4'd10));
`endif
        isDivOp     = (op == 4'd3) || (op == 4'd4);
        startSigned = (op == 4'd4);
        aMag        = (startSigned && a[WIDTH-1]) ? -a : a;
        bMag        = (startSigned && b[WIDTH-1]) ? -b : b;
    end

    // Operands are extended to full product width so truncation is modulo 2^(2*WIDTH).
    always_comb begin
        mulSigned = (opReg == 4'd2) || (opReg == 4'd8) || (opReg == 4'd10);
        aExt      = mulSigned ? {{WIDTH{aReg[WIDTH-1]}}, aReg} : {{WIDTH{1'b0}}, aReg};
        bExt      = mulSigned ? {{WIDTH{bReg[WIDTH-1]}}, bReg} : {{WIDTH{1'b0}}, bReg};
        product   = aExt * bExt;
        mulResult = product;
`ifdef MD_UNIT_MADD_EN
        if ((opReg == 4'd7) || (opReg == 4'd8))
            mulResult = {hi, lo} + product;
        else if ((opReg == 4'd9) || (opReg == 4'd10))
            mulResult = {hi, lo} - product;
`endif
    end

    // Restoring step: partial remainder always stays below the divisor, so WIDTH bits suffice.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        stepGeq  = shifted >= {1'b0, divisor};
        stepDiff = shifted[WIDTH-1:0] - divisor;
        quoFinal = negQ ? -quo : quo;
        remFinal = negR ? -rem : rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            opReg   <= '0;
            aReg    <= '0;
            bReg    <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (isMulOp) begin
                            opReg <= op;
                            aReg  <= a;
                            bReg  <= b;
                            count <= CW'(MULT_LAT - 1);
                            state <= MUL;
                            busy  <= 1'b1;
                        end else if (isDivOp) begin
                            opReg   <= op;
                            aReg    <= a;
                            bReg    <= b;
                            quo     <= aMag;
                            divisor <= bMag;
                            rem     <= '0;
                            negQ    <= startSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                            negR    <= startSigned && a[WIDTH-1];
                            divZero <= (b == '0);
                            count   <= CW'(WIDTH);
                            state   <= DIV;
                            busy    <= 1'b1;
                        end else if (op == 4'd5) begin
                            hi <= a;
                        end else if (op == 4'd6) begin
                            lo <= a;
                        end
                    end
                end
                MUL: begin
                    if (count == '0) begin
                        {hi, lo} <= mulResult;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DIV: begin
                    rem   <= stepGeq ? stepDiff : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], stepGeq};
                    count <= count - 1'b1;
                    if (count == CW'(1))
                        state <= DONE_DIV;
                end
                DONE_DIV: begin
                    if (divZero) begin
                        lo <= '1;
                        hi <= aReg;
                    end else begin
                        lo <= quoFinal;
                        hi <= remFinal;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit (WIDTH=32, MULT_LAT=5).
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic [31:0] hi, lo;
    logic        busy;
    int          passCount = 0;
    int          checkCount = 0;

    md_unit #(.WIDTH(32), .MULT_LAT(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        waitEdges(1);
        checkCount++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want %h", hi, 32'h0); else passCount++;
        checkCount++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want %h", lo, 32'h0); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passCount++;
    endtask

    task automatic test_mult;
        issue(4'd2, 32'hFFFFFFFE, 32'd3);
        checkCount++; if (busy !== 1'b1) $display("FAIL mult_busy_e0: got %b want 1", busy); else passCount++;
        waitEdges(4);
        checkCount++; if (busy !== 1'b1) $display("FAIL mult_busy_e4: got %b want 1", busy); else passCount++;
        waitEdges(1);
        checkCount++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFFFFFF); else passCount++;
        checkCount++; if (lo !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFFFFFA); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL mult_busy_done: got %b want 0", busy); else passCount++;
        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        waitEdges(5);
        checkCount++; if (hi !== 32'h2) $display("FAIL multu_hi: got %h want %h", hi, 32'h2); else passCount++;
        checkCount++; if (lo !== 32'hFFFFFFFA) $display("FAIL multu_lo: got %h want %h", lo, 32'hFFFFFFFA); else passCount++;
    endtask

    task automatic test_div;
        issue(4'd4, 32'hFFFFFFF9, 32'd2);
        waitEdges(32);
        checkCount++; if (busy !== 1'b1) $display("FAIL div_busy_e32: got %b want 1", busy); else passCount++;
        waitEdges(1);
        checkCount++; if (busy !== 1'b0) $display("FAIL div_busy_done: got %b want 0", busy); else passCount++;
        checkCount++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want %h", lo, 32'hFFFFFFFD); else passCount++;
        checkCount++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want %h", hi, 32'hFFFFFFFF); else passCount++;
        issue(4'd4, 32'h80000000, 32'hFFFFFFFF);
        waitEdges(33);
        checkCount++; if (lo !== 32'h80000000) $display("FAIL divmin_lo: got %h want %h", lo, 32'h80000000); else passCount++;
        checkCount++; if (hi !== 32'h0) $display("FAIL divmin_hi: got %h want %h", hi, 32'h0); else passCount++;
        issue(4'd3, 32'd100, 32'd7);
        waitEdges(33);
        checkCount++; if (lo !== 32'd14) $display("FAIL divu_lo: got %h want %h", lo, 32'd14); else passCount++;
        checkCount++; if (hi !== 32'd2) $display("FAIL divu_hi: got %h want %h", hi, 32'd2); else passCount++;
    endtask

    task automatic test_div_zero;
        issue(4'd3, 32'd5, 32'd0);
        waitEdges(2);
        issue(4'd5, 32'h1234, 32'd0);
        waitEdges(29);
        checkCount++; if (busy !== 1'b1) $display("FAIL divz_busy_e32: got %b want 1", busy); else passCount++;
        waitEdges(1);
        checkCount++; if (lo !== 32'hFFFFFFFF) $display("FAIL divz_lo: got %h want %h", lo, 32'hFFFFFFFF); else passCount++;
        checkCount++; if (hi !== 32'd5) $display("FAIL divz_hi: got %h want %h", hi, 32'd5); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL divz_busy_done: got %b want 0", busy); else passCount++;
    endtask

    task automatic test_cancel;
        issue(4'd3, 32'd100, 32'd7);
        waitEdges(18);
        cancel = 1'b1;
        waitEdges(1);
        cancel = 1'b0;
        checkCount++; if (busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", busy); else passCount++;
        waitEdges(40);
        checkCount++; if (hi !== 32'd5) $display("FAIL cancel_hi: got %h want %h", hi, 32'd5); else passCount++;
        checkCount++; if (lo !== 32'hFFFFFFFF) $display("FAIL cancel_lo: got %h want %h", lo, 32'hFFFFFFFF); else passCount++;
        cancel = 1'b1;
        issue(4'd6, 32'd77, 32'd0);
        cancel = 1'b0;
        checkCount++; if (lo !== 32'hFFFFFFFF) $display("FAIL cancel_start_lo: got %h want %h", lo, 32'hFFFFFFFF); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL cancel_start_busy: got %b want 0", busy); else passCount++;
        issue(4'd2, 32'd2, 32'd3);
        waitEdges(3);
        cancel = 1'b1;
        waitEdges(1);
        cancel = 1'b0;
        checkCount++; if (lo !== 32'hFFFFFFFF) $display("FAIL cancel_mul_lo: got %h want %h", lo, 32'hFFFFFFFF); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL cancel_mul_busy: got %b want 0", busy); else passCount++;
        waitEdges(5);
        checkCount++; if (hi !== 32'd5) $display("FAIL cancel_mul_hi: got %h want %h", hi, 32'd5); else passCount++;
    endtask

    task automatic test_reset_mid;
        issue(4'd3, 32'd100, 32'd7);
        waitEdges(9);
        reset = 1'b1;
        #1;
        checkCount++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (hi !== 32'h0) $display("FAIL rstmid_hi: got %h want %h", hi, 32'h0); else passCount++;
        checkCount++; if (lo !== 32'h0) $display("FAIL rstmid_lo: got %h want %h", lo, 32'h0); else passCount++;
        #1;
        reset = 1'b0;
        waitEdges(40);
        checkCount++; if (lo !== 32'h0) $display("FAIL rstmid_late_lo: got %h want %h", lo, 32'h0); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL rstmid_late_busy: got %b want 0", busy); else passCount++;
    endtask

    task automatic test_mthi_mtlo;
        issue(4'd5, 32'h0000AAAA, 32'd0);
        checkCount++; if (hi !== 32'h0000AAAA) $display("FAIL mthi_hi: got %h want %h", hi, 32'h0000AAAA); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else passCount++;
        issue(4'd6, 32'h00005555, 32'd0);
        checkCount++; if (lo !== 32'h00005555) $display("FAIL mtlo_lo: got %h want %h", lo, 32'h00005555); else passCount++;
    endtask

    task automatic test_madd;
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd10, 32'd0);
        issue(4'd8, 32'd3, 32'd4);
`ifdef MD_UNIT_MADD_EN
        checkCount++; if (busy !== 1'b1) $display("FAIL madd_busy: got %b want 1", busy); else passCount++;
        waitEdges(5);
        checkCount++; if (lo !== 32'd22) $display("FAIL madd_lo: got %h want %h", lo, 32'd22); else passCount++;
        checkCount++; if (hi !== 32'd0) $display("FAIL madd_hi: got %h want %h", hi, 32'd0); else passCount++;
        issue(4'd9, 32'd1, 32'd30);
        waitEdges(5);
        checkCount++; if (hi !== 32'hFFFFFFFF) $display("FAIL msubu_hi: got %h want %h", hi, 32'hFFFFFFFF); else passCount++;
        checkCount++; if (lo !== 32'hFFFFFFF8) $display("FAIL msubu_lo: got %h want %h", lo, 32'hFFFFFFF8); else passCount++;
`else
        checkCount++; if (busy !== 1'b0) $display("FAIL madd_off_busy: got %b want 0", busy); else passCount++;
        waitEdges(6);
        checkCount++; if (lo !== 32'd10) $display("FAIL madd_off_lo: got %h want %h", lo, 32'd10); else passCount++;
        checkCount++; if (hi !== 32'd0) $display("FAIL madd_off_hi: got %h want %h", hi, 32'd0); else passCount++;
`endif
    endtask

    task automatic test_back_to_back;
        issue(4'd1, 32'd9, 32'd9);
        waitEdges(5);
        checkCount++; if (lo !== 32'd81) $display("FAIL b2b_first_lo: got %h want %h", lo, 32'd81); else passCount++;
        issue(4'd1, 32'd7, 32'd6);
        checkCount++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passCount++;
        waitEdges(5);
        checkCount++; if (lo !== 32'd42) $display("FAIL b2b_lo: got %h want %h", lo, 32'd42); else passCount++;
        checkCount++; if (hi !== 32'd0) $display("FAIL b2b_hi: got %h want %h", hi, 32'd0); else passCount++;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_cancel;
        test_reset_mid;
        test_mthi_mtlo;
        test_madd;
        test_back_to_back;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
